// File: rtl/ssp_tx_serializer.sv
// ssp_tx_serializer
// Pops words from the TX FIFO and sends them MSB-first in TI synchronous
// serial format: a one-bit-period frame pulse followed by WORD_SIZE data bits.
// Consecutive words chain with no idle gap while the FIFO stays non-empty.
// WORD_SIZE must be at least 2, because the next word is fetched on the tick
// that puts the LSB on the line.
module ssp_tx_serializer #(
   parameter int WORD_SIZE = 8
) (
   input  logic                 PCLK,
   input  logic                 CLEAR_B,
   input  logic [WORD_SIZE-1:0] TXDATA,
   input  logic                 FIFOEMPTY,
   output logic                 read,
   output logic                 SSPCLKOUT,
   output logic                 SSPFSSOUT,
   output logic                 SSPTXD,
   output logic                 SSPOE_B,
   output logic                 TX_BUSY
);

   localparam int              CW       = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
   localparam logic [CW-1:0]   CNT_TOP  = CW'(WORD_SIZE - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t                r_state;
   logic [WORD_SIZE-1:0]  r_shift;
   logic [CW-1:0]         r_cnt;
   logic                  r_sclk;
   logic                  r_txd;
   logic                  r_fss;
   logic                  r_oe_b;
   logic                  r_read;
   logic                  r_busy;

   logic                  w_tick;
   logic                  w_next_bit;

   // A tick is the PCLK edge on which the serial clock rises.
   assign w_tick = ~r_sclk;

   // Bit that follows the one currently on SSPTXD; the shift register is
   // never shifted, the counter selects the bit instead.
   always_comb begin
      w_next_bit = 1'b0;
      if (r_cnt != CNT_ZERO) begin
         w_next_bit = r_shift[r_cnt - CNT_ONE];
      end else begin
         w_next_bit = 1'b0;
      end
   end

   // Serial clock: free-running PCLK/2 toggle register.
   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         r_sclk <= 1'b0;
      end else begin
         r_sclk <= ~r_sclk;
      end
   end

   // Framing FSM: loads words, drives frame pulse, data, enable and pop strobe.
   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_cnt   <= CNT_ZERO;
         r_txd   <= 1'b0;
         r_fss   <= 1'b0;
         r_oe_b  <= 1'b1;
         r_read  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         // pop strobe lasts exactly one PCLK
         r_read <= 1'b0;
         if (w_tick) begin
            case (r_state)
               ST_IDLE: begin
                  if (!FIFOEMPTY) begin
                     r_shift <= TXDATA;
                     r_fss   <= 1'b1;
                     r_oe_b  <= 1'b0;
                     r_read  <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= ST_FRAME;
                  end
               end
               ST_FRAME: begin
                  r_fss   <= 1'b0;
                  r_txd   <= r_shift[WORD_SIZE-1];
                  r_cnt   <= CNT_TOP;
                  r_state <= ST_SHIFT;
               end
               ST_SHIFT: begin
                  if (r_cnt != CNT_ZERO) begin
                     r_txd <= w_next_bit;
                     r_cnt <= r_cnt - CNT_ONE;
                     // LSB goes out now; fetch the next word in parallel
                     if ((r_cnt == CNT_ONE) && !FIFOEMPTY) begin
                        r_shift <= TXDATA;
                        r_fss   <= 1'b1;
                        r_read  <= 1'b1;
                     end
                  end else if (r_fss) begin
                     // next word already loaded: its MSB follows directly
                     r_fss <= 1'b0;
                     r_txd <= r_shift[WORD_SIZE-1];
                     r_cnt <= CNT_TOP;
                  end else begin
                     r_txd   <= 1'b0;
                     r_oe_b  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
               default: begin
                  r_fss   <= 1'b0;
                  r_txd   <= 1'b0;
                  r_oe_b  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign read      = r_read;
   assign SSPCLKOUT = r_sclk;
   assign SSPFSSOUT = r_fss;
   assign SSPTXD    = r_txd;
   assign SSPOE_B   = r_oe_b;
   assign TX_BUSY   = r_busy;

endmodule

// File: doc/ssp_tx_serializer.md
# ssp_tx_serializer

Transmit serializer for the SSP master. It sits directly downstream of the transmit FIFO and pops one word at a time from it. Each word goes out MSB-first on a TI synchronous-serial-format link: a one-bit-period frame pulse, then `SSP_WORD_SIZE` data bits. Back-to-back words are sent with no idle gap while the FIFO stays non-empty.

## Interface
Parameters:
- WORD_SIZE, default `SSP_WORD_SIZE` (8): bits per frame.

Ports:
- PCLK  in  1  system clock; all registers are rising-edge.
- CLEAR_B  in  1  reset, asynchronous, active-low.
- TXDATA  in  WORD_SIZE  head word of the TX FIFO (FIFO DATA_OUT), valid while FIFOEMPTY=0.
- FIFOEMPTY  in  1  TX FIFO empty flag.
- read  out  1  FIFO pop strobe, registered, one PCLK wide per word.
- SSPCLKOUT  out  1  serial clock, PCLK/2, free-running.
- SSPFSSOUT  out  1  frame sync, high for one SSPCLKOUT period before the MSB.
- SSPTXD  out  1  serial data, registered.
- SSPOE_B  out  1  output enable for SSPTXD, active-low.
- TX_BUSY  out  1  high whenever the state is not IDLE.

## Operation
- SSPCLKOUT comes from a toggle register, 0 after reset, that inverts on every PCLK edge.
- A "tick" is a PCLK edge on which SSPCLKOUT goes 0->1. All state, SSPTXD, SSPFSSOUT and SSPOE_B updates happen only on ticks.
- The receiver samples on SSPCLKOUT falling edges.
- Shift register: WORD_SIZE bits. Bit counter: clog2(WORD_SIZE) bits, counts WORD_SIZE-1 down to 0.
- States: IDLE, FRAME, SHIFT.
  - IDLE, tick, FIFOEMPTY=0: latch TXDATA into the shift register; SSPFSSOUT<=1; SSPOE_B<=0; read<=1; go to FRAME.
  - IDLE, tick, FIFOEMPTY=1: remain in IDLE; all outputs keep their idle values.
  - FRAME, tick: SSPFSSOUT<=0; SSPTXD<=shift[WORD_SIZE-1]; counter<=WORD_SIZE-1; go to SHIFT. FIFOEMPTY is ignored in FRAME.
  - SHIFT, tick, counter>0: SSPTXD<=next bit; counter decrements.
  - When counter reaches 0, SSPTXD is driving the LSB. On that same tick, if FIFOEMPTY=0: load the next word, SSPFSSOUT<=1, read<=1. The LSB is still driven in parallel; SSPTXD is a separate register from the shift register.
  - SHIFT, tick, counter=0, SSPFSSOUT=1 (next word already loaded): behave as the FRAME tick, i.e. MSB of the new word and no idle gap.
  - SHIFT, tick, counter=0, no word loaded: SSPTXD<=0; SSPOE_B<=1; go to IDLE.
- read: set on the tick that loads a word and cleared on the following PCLK edge. It is never high for more than one cycle, and there is exactly one pulse per word transmitted.
- The popped word is owned by the serializer. The FIFO pointer advances one PCLK after the load.

## Timing
- Reset values (asynchronous while CLEAR_B=0): SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, read=0, TX_BUSY=0, state IDLE, counter 0, shift register 0.
- First tick after CLEAR_B deasserts occurs 1 PCLK after release.
- Start latency: from the FIFOEMPTY fall, the load tick occurs after 0–1 PCLK wait, depending on phase.
- After the load tick, the MSB appears 2 PCLK later and the LSB 2*WORD_SIZE PCLK later.
- Per-word periods, in PCLK:
  - SSPFSSOUT high: 2 PCLK.
  - Each data bit: 2 PCLK.
  - Back-to-back frame period: 2*WORD_SIZE PCLK.
  - Isolated word: SSPOE_B low for 2+2*WORD_SIZE PCLK.
- If FIFOEMPTY rises in the same cycle as read, no extra pop occurs: the serializer samples FIFOEMPTY only on ticks.
- If CLEAR_B is asserted mid-frame, the frame is abandoned immediately, the word is lost, and outputs take reset values. This is consistent with CLEAR_B also flushing the FIFO.
- Wrap-around: the counter reloads, never underflows. The shift register is only written on a load tick.

## Test plan
- Reset: hold CLEAR_B=0 with FIFOEMPTY=0 -> SSPOE_B=1, read=0, SSPCLKOUT=0, TX_BUSY=0 throughout. After release, SSPCLKOUT toggles every PCLK.
- Single word: TXDATA=8'hA5, FIFOEMPTY falls then rises after read.
  - Exactly one read pulse.
  - SSPFSSOUT high 2 PCLK, then SSPTXD=1,0,1,0,0,1,0,1, each bit 2 PCLK.
  - SSPOE_B low 18 PCLK, then 1; TX_BUSY back to 0.
- Back-to-back: FIFO holds 8'h3C, 8'hC3.
  - Second SSPFSSOUT pulse overlaps the LSB of 8'h3C.
  - 8'hC3 MSB follows with no gap; two read pulses 16 PCLK apart.
- Late arrival: FIFOEMPTY falls during the FRAME tick of a word -> no pop until that word's LSB tick, then seamless chaining.
- Empty idle: FIFOEMPTY=1 for 100 PCLK -> read never asserts, SSPOE_B stays 1, SSPTXD stays 0.
- Mid-frame reset: assert CLEAR_B=0 after the fourth bit of 8'hFF -> all outputs reach reset values in the same cycle. After release with FIFO empty, nothing is transmitted.
